// File: rtl/txn_profile_recorder.sv
// txn_profile_recorder: per-transaction latency/iteration/stall profiler with a record FIFO
// Ports: ap_clk/ap_rst_n clock and async active-low reset; clr sync clear
//   ap_start/ap_done kernel handshake; iter_end_en/stall pipeline taps
//   rec_* head record with rec_valid/rec_ready handshake; busy open transaction
//   drop_cnt saturating count of records lost to a full FIFO
module txn_profile_recorder #(
  parameter int CNT_W  = 32,
  parameter int ITER_W = 16,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              clr,
  input  logic              ap_start,
  input  logic              ap_done,
  input  logic              iter_end_en,
  input  logic              stall,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [CNT_W-1:0]  rec_start_ts,
  output logic [CNT_W-1:0]  rec_latency,
  output logic [ITER_W-1:0] rec_iters,
  output logic [CNT_W-1:0]  rec_stalls,
  output logic              rec_sat,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = 3 * CNT_W + ITER_W + 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] ts, ts0_q, ts0_n, lat_q, lat_n, st_q, st_n, st_b;
  logic [ITER_W-1:0] it_q, it_n, it_b;
  logic sat_q, sat_n, act, win, it_ev, push, pop, full, empty, wr_en, drop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] head;
  // The *_n values are the running totals including the current cycle; in IDLE
  // they restart from zero so the start cycle itself is counted.
  assign act = state == ACTIVE;
  assign win = act | ap_start;
  assign it_ev = iter_end_en & ~stall;
  assign it_b = act ? it_q : '0;
  assign st_b = act ? st_q : '0;
  assign ts0_n = act ? ts0_q : ts;
  assign lat_n = !act ? '0 : (&lat_q) ? lat_q : lat_q + CNT_W'(1);
  assign it_n = (it_ev & ~(&it_b)) ? it_b + ITER_W'(1) : it_b;
  assign st_n = (stall & ~(&st_b)) ? st_b + CNT_W'(1) : st_b;
  // Saturation is flagged when an increment is attempted on an all-ones count.
  assign sat_n = (act & (sat_q | (&lat_q))) | (it_ev & (&it_b)) | (stall & (&st_b));
  assign push = win & ap_done & ~clr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign pop = ~empty & rec_ready;
  assign wr_en = push & (~full | pop);
  assign drop = push & full & ~pop;
  assign head = mem[rd_ptr[AW-1:0]];
  assign rec_valid = ~empty;
  assign {rec_start_ts, rec_latency, rec_iters, rec_stalls, rec_sat} = rec_valid ? head : '0;
  assign busy = act;
  always_comb begin
    state_n = IDLE;
    state_n = clr ? IDLE : (win & ~ap_done) ? ACTIVE : IDLE;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      ts <= '0;
      ts0_q <= '0;
      lat_q <= '0;
      it_q <= '0;
      st_q <= '0;
      sat_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_cnt <= '0;
    end else begin
      ts <= ts + CNT_W'(1);
      ts0_q <= ts0_n;
      lat_q <= lat_n;
      it_q <= it_n;
      st_q <= st_n;
      sat_q <= sat_n;
      wr_ptr <= clr ? '0 : wr_ptr + PW'(wr_en);
      rd_ptr <= clr ? '0 : rd_ptr + PW'(pop);
      drop_cnt <= clr ? '0 : (drop & ~(&drop_cnt)) ? drop_cnt + DROP_W'(1) : drop_cnt;
    end
  always_ff @(posedge ap_clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {ts0_n, lat_n, it_n, st_n, sat_n};
endmodule

// File: tb/tb_txn_profile_recorder.sv
// tb_txn_profile_recorder: table-driven and scoreboard bench for txn_profile_recorder
module tb_txn_profile_recorder;
  localparam int DEPTH = 8;
  logic ap_clk = 0, ap_rst_n = 0, clr = 0, ap_start = 0, ap_done = 0;
  logic iter_end_en = 0, stall = 0, rec_ready = 0;
  logic rec_valid, rec_sat, busy;
  logic [31:0] rec_start_ts, rec_latency, rec_stalls;
  logic [15:0] rec_iters, drop_cnt;
  logic v4, sat4, busy4;
  logic [3:0] ts4, lat4, st4;
  logic [15:0] it4, drop4;
  typedef struct {
    logic [63:0] ts, lat, it, st;
    logic        sat;
  } rec_t;
  typedef struct {
    int len, ni, ns, e_lat, e_it, e_st;
  } vec_t;
  rec_t q[$];
  vec_t tab[10];
  int checks = 0, errors = 0, exp_drop = 0, cyc;

  txn_profile_recorder dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr), .ap_start(ap_start),
    .ap_done(ap_done), .iter_end_en(iter_end_en), .stall(stall),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_start_ts(rec_start_ts),
    .rec_latency(rec_latency), .rec_iters(rec_iters), .rec_stalls(rec_stalls),
    .rec_sat(rec_sat), .busy(busy), .drop_cnt(drop_cnt));

  txn_profile_recorder #(.CNT_W(4)) dut4 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr), .ap_start(ap_start),
    .ap_done(ap_done), .iter_end_en(iter_end_en), .stall(stall),
    .rec_valid(v4), .rec_ready(rec_ready), .rec_start_ts(ts4),
    .rec_latency(lat4), .rec_iters(it4), .rec_stalls(st4),
    .rec_sat(sat4), .busy(busy4), .drop_cnt(drop4));

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction

  task automatic chk_head(string n, rec_t e);
    chk({n, " valid"}, 64'(rec_valid), 1);
    chk({n, " start_ts"}, 64'(rec_start_ts), e.ts);
    chk({n, " latency"}, 64'(rec_latency), e.lat);
    chk({n, " iters"}, 64'(rec_iters), e.it);
    chk({n, " stalls"}, 64'(rec_stalls), e.st);
    chk({n, " sat"}, 64'(rec_sat), 64'(e.sat));
  endtask

  task automatic push_exp(rec_t r);
    if (q.size() == DEPTH) exp_drop++;
    else q.push_back(r);
  endtask

  // Called at a negedge; returns at the negedge after the done cycle with
  // out-of-window noise on iter_end_en/stall.
  task automatic txn(int len, int ni, int ns, bit pop_done, bit clr_done, output int ts0);
    rec_t d;
    ts0 = cyc;
    for (int i = 0; i <= len; i++) begin
      if (i > 0) @(negedge ap_clk);
      ap_start = i == 0;
      ap_done = i == len;
      stall = i < ns;
      iter_end_en = i >= ns && i < ns + ni;
      clr = i == len && clr_done;
      if (i == len && pop_done) begin
        chk_head("pop at done", q[0]);
        d = q.pop_front();
        rec_ready = 1;
      end
    end
    @(negedge ap_clk);
    ap_start = 0;
    ap_done = 0;
    clr = 0;
    rec_ready = 0;
    iter_end_en = 1;
    stall = 1;
  endtask

  task automatic drain();
    rec_t e;
    for (int k = 0; k < 64; k++) begin
      @(negedge ap_clk);
      if (rec_valid) begin
        if (q.size() == 0) chk("extra record", 64'(rec_valid), 0);
        else begin
          e = q.pop_front();
          chk_head("drain", e);
        end
        rec_ready = 1;
      end else begin
        rec_ready = 0;
        if (q.size() == 0) break;
      end
    end
    rec_ready = 0;
    if (q.size() != 0) begin
      chk("drain leftover", 64'(q.size()), 0);
      q.delete();
    end
  endtask

  initial begin
    rec_t e;
    int t0, tb0;
    tab = '{
      '{3, 2, 1, 3, 2, 1}, '{1, 1, 1, 1, 1, 1}, '{0, 0, 1, 0, 0, 1},
      '{7, 4, 4, 7, 4, 4}, '{2, 0, 0, 2, 0, 0}, '{5, 5, 0, 5, 5, 0},
      '{4, 0, 5, 4, 0, 5}, '{6, 3, 2, 6, 3, 2}, '{1, 0, 0, 1, 0, 0},
      '{9, 6, 4, 9, 6, 4}};
    repeat (3) @(negedge ap_clk);
    chk("reset rec_valid", 64'(rec_valid), 0);
    chk("reset busy", 64'(busy), 0);
    chk("reset drop_cnt", 64'(drop_cnt), 0);
    chk("reset latency", 64'(rec_latency), 0);
    chk("reset start_ts", 64'(rec_start_ts), 0);
    ap_rst_n = 1;
    iter_end_en = 1;
    stall = 1;
    // Basic transaction: start at 10, done at 25.
    while (cyc < 10) @(negedge ap_clk);
    txn(15, 8, 3, 0, 0, t0);
    chk("t1 busy after done", 64'(busy), 0);
    e = '{ts: 10, lat: 15, it: 8, st: 3, sat: 0};
    chk_head("t1 cycle 26", e);
    push_exp(e);
    drain();
    // Start and done in the same idle cycle.
    while (cyc < 40) @(negedge ap_clk);
    txn(0, 1, 0, 0, 0, t0);
    chk("t2 busy", 64'(busy), 0);
    e = '{ts: 40, lat: 0, it: 1, st: 0, sat: 0};
    chk_head("t2 zero latency", e);
    push_exp(e);
    drain();
    // ap_start held high: four back-to-back 5-cycle transactions.
    tb0 = cyc;
    ap_start = 1;
    iter_end_en = 0;
    stall = 0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge ap_clk);
      ap_done = c % 6 == 5;
      if (c == 1) chk("t3 busy open", 64'(busy), 1);
      if (c == 6) chk("t3 busy restart gap", 64'(busy), 0);
      if (c == 7) chk("t3 busy reopen", 64'(busy), 1);
    end
    @(negedge ap_clk);
    ap_start = 0;
    ap_done = 0;
    for (int k = 0; k < 4; k++) push_exp('{ts: tb0 + 6 * k, lat: 5, it: 0, st: 0, sat: 0});
    chk("t3 drop_cnt", 64'(drop_cnt), 0);
    chk_head("t3 head", q[0]);
    repeat (3) @(negedge ap_clk);
    chk_head("t3 head held", q[0]);
    drain();
    // Ten queued transactions with no consumer: two must be dropped.
    foreach (tab[k]) begin
      txn(tab[k].len, tab[k].ni, tab[k].ns, 0, 0, t0);
      push_exp('{ts: t0, lat: tab[k].e_lat, it: tab[k].e_it, st: tab[k].e_st, sat: 0});
    end
    chk("t4 drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("t4 drop_cnt two", 64'(drop_cnt), 2);
    txn(3, 1, 1, 1, 0, t0);
    push_exp('{ts: t0, lat: 3, it: 1, st: 1, sat: 0});
    chk("t4 push+pop when full", 64'(drop_cnt), 2);
    drain();
    // clr in the done cycle: nothing recorded and the drop count clears.
    txn(4, 1, 1, 0, 1, t0);
    chk("clr rec_valid", 64'(rec_valid), 0);
    chk("clr busy", 64'(busy), 0);
    chk("clr drop_cnt", 64'(drop_cnt), 0);
    chk("clr narrow rec_valid", 64'(v4), 0);
    // Saturation in the CNT_W=4 instance; the wide instance records exact counts.
    txn(20, 2, 18, 0, 0, t0);
    chk("sat4 valid", 64'(v4), 1);
    chk("sat4 start_ts wrap", 64'(ts4), 64'(t0 % 16));
    chk("sat4 latency", 64'(lat4), 15);
    chk("sat4 iters", 64'(it4), 2);
    chk("sat4 stalls", 64'(st4), 15);
    chk("sat4 sat", 64'(sat4), 1);
    push_exp('{ts: t0, lat: 20, it: 2, st: 18, sat: 0});
    drain();
    // Reset in the middle of an open transaction discards it.
    @(negedge ap_clk);
    ap_start = 1;
    ap_done = 0;
    @(negedge ap_clk);
    ap_start = 0;
    repeat (3) @(negedge ap_clk);
    chk("rst busy before", 64'(busy), 1);
    ap_rst_n = 0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1;
    chk("rst busy after", 64'(busy), 0);
    chk("rst rec_valid after", 64'(rec_valid), 0);
    chk("rst drop_cnt after", 64'(drop_cnt), 0);
    ap_done = 1;
    @(negedge ap_clk);
    ap_done = 0;
    @(negedge ap_clk);
    chk("rst stray done ignored", 64'(rec_valid), 0);
    chk("rst busy stays low", 64'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
